// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: ID-stage control in, instruction ROM port, IF/ID register out.
// master = the fetch stage, slave = the surrounding pipeline / ROM.
interface if_fetch_stage_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        halted;

  modport master (
    input  stall, branch_taken, branch_target, jump, jump_index, jr, jr_target,
    input  imem_instr,
    output imem_addr, id_instr, id_pc_plus4, id_valid, halted
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, jump_index, jr, jr_target,
    output imem_instr,
    input  imem_addr, id_instr, id_pc_plus4, id_valid, halted
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and captures the
// returned word into the IF/ID register. Handles ID stall and redirects
// (branch > j > jr) with flush.
// Optional macro FETCH_HALT_DETECT_EN: detect a jump-to-self in IF/ID and park
// the stage in HALT until reset.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  if_fetch_stage_if.master bus
);

`ifdef FETCH_HALT_DETECT_EN
  typedef enum logic {RUN, HALT} state_t;
`else
  typedef enum logic {RUN} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pp4_q, pp4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        redirect;
`ifdef FETCH_HALT_DETECT_EN
  logic        halted_q, halted_d;
  logic [31:0] self_target;
  logic        halt_hit;
`endif

  // Next-state and next-PC selection for the fetch FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pp4_d    = pp4_q;
    valid_d  = valid_q;
    pc_plus4 = pc_q + 32'd4;
    redirect = bus.branch_taken | bus.jump | bus.jr;

    if (bus.branch_taken)
      redirect_target = bus.branch_target & ~32'h3;
    else if (bus.jump)
      redirect_target = {pp4_q[31:28], bus.jump_index, 2'b00};
    else
      redirect_target = bus.jr_target & ~32'h3;

`ifdef FETCH_HALT_DETECT_EN
    halted_d    = halted_q;
    self_target = {pp4_q[31:28], instr_q[25:0], 2'b00};
    halt_hit    = valid_q && !bus.stall && (instr_q[31:26] == 6'h02)
                  && (self_target == pp4_q - 32'd4);
`endif

    case (state_q)
      RUN: begin
`ifdef FETCH_HALT_DETECT_EN
        if (halt_hit) begin
          // Jump-to-self in ID: park at the target with the pipe flushed.
          state_d  = HALT;
          halted_d = 1'b1;
          pc_d     = self_target;
          instr_d  = 32'h0;
          pp4_d    = 32'h0;
          valid_d  = 1'b0;
        end else
`endif
        if (redirect) begin
          // Redirect wins over stall; the wrong-path fetch is squashed.
          pc_d    = redirect_target;
          instr_d = 32'h0;
          pp4_d   = 32'h0;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          pc_d    = pc_plus4;
          instr_d = bus.imem_instr;
          pp4_d   = pc_plus4;
          valid_d = 1'b1;
        end
      end
`ifdef FETCH_HALT_DETECT_EN
      HALT: begin
        // Frozen: all inputs other than reset are ignored.
        instr_d = 32'h0;
        valid_d = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  // State, PC and IF/ID registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pp4_q   <= 32'h0;
      valid_q <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp4_q   <= pp4_d;
      valid_q <= valid_d;
`ifdef FETCH_HALT_DETECT_EN
      halted_q <= halted_d;
`endif
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.id_instr    = instr_q;
  assign bus.id_pc_plus4 = pp4_q;
  assign bus.id_valid    = valid_q;
`ifdef FETCH_HALT_DETECT_EN
  assign bus.halted      = halted_q;
`else
  assign bus.halted      = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: the driver applies stimulus on the
// falling edge, advances a behavioural model and queues the expected outputs;
// the monitor pops and compares just after each rising edge.
module tb_if_fetch_stage;
  logic clk = 1'b0;
  logic reset;
  if_fetch_stage_if bus ();

  if_fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Small instruction ROM, aliased every 256 bytes.
  logic [31:0] rom [64];
  assign bus.imem_instr = rom[bus.imem_addr[7:2]];

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        bt;
    logic [31:0] btgt;
    logic        j;
    logic [25:0] jidx;
    logic        jr;
    logic [31:0] jrtgt;
  } stim_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model state: architectural view of PC and IF/ID.
  logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_pp4 = 32'h0;
  logic        m_valid = 1'b0, m_halted = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // One clock of the model, following the fetch rules directly.
  task automatic model_step(input stim_t s);
    logic [31:0] fetched;
    logic [31:0] tgt;
    fetched = rom[m_pc[7:2]];
    if (!s.rst_n) begin
      m_pc = 32'h0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_halted = 0;
    end else if (m_halted) begin
      m_instr = 0; m_valid = 0;
    end
`ifdef FETCH_HALT_DETECT_EN
    else if (m_valid && !s.stall && m_instr[31:26] == 6'h02 &&
             {m_pp4[31:28], m_instr[25:0], 2'b00} == m_pp4 - 4) begin
      m_pc = {m_pp4[31:28], m_instr[25:0], 2'b00};
      m_instr = 0; m_pp4 = 0; m_valid = 0; m_halted = 1;
    end
`endif
    else if (s.bt || s.j || s.jr) begin
      if (s.bt)     tgt = s.btgt;
      else if (s.j) tgt = {m_pp4[31:28], s.jidx, 2'b00};
      else          tgt = s.jrtgt;
      tgt[1:0] = 2'b00;
      m_pc = tgt; m_instr = 0; m_pp4 = 0; m_valid = 0;
    end else if (!s.stall) begin
      m_instr = fetched;
      m_pp4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1;
    end
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    @(negedge clk);
    reset             = s.rst_n;
    bus.stall         = s.stall;
    bus.branch_taken  = s.bt;
    bus.branch_target = s.btgt;
    bus.jump          = s.j;
    bus.jump_index    = s.jidx;
    bus.jr            = s.jr;
    bus.jr_target     = s.jrtgt;
    model_step(s);
    e.addr = m_pc; e.instr = m_instr; e.pp4 = m_pp4; e.valid = m_valid; e.halted = m_halted;
    sb_q.push_back(e);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1; s.stall = 0; s.bt = 0; s.btgt = 0; s.j = 0; s.jidx = 0; s.jr = 0; s.jrtgt = 0;
    return s;
  endfunction

  // Monitor: compare every output just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("imem_addr",   bus.imem_addr,   e.addr);
        check("id_instr",    bus.id_instr,    e.instr);
        check("id_pc_plus4", bus.id_pc_plus4, e.pp4);
        check("id_valid",    {31'h0, bus.id_valid}, {31'h0, e.valid});
        check("halted",      {31'h0, bus.halted},   {31'h0, e.halted});
      end
    end
  end

  initial begin
    stim_t s;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h2408_0000;
    rom[1] = 32'h2409_0000;
    reset = 1'b0;
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
    bus.jump = 0; bus.jump_index = 0; bus.jr = 0; bus.jr_target = 0;

    // Reset, then sequential fetch of word0 / word1 and on to PC=0x14.
    s = idle(); s.rst_n = 0;
    repeat (2) drive(s);
    repeat (5) drive(idle());

    // Stall three cycles at PC=0x14, then resume.
    s = idle(); s.stall = 1;
    repeat (3) drive(s);
    drive(idle());

    // Branch together with stall: branch wins, target low bits dropped.
    s = idle(); s.stall = 1; s.bt = 1; s.btgt = 32'h2E;
    drive(s);
    drive(idle());

    // Set up id_pc_plus4 = 0x10000008, then j with index 5.
    s = idle(); s.jr = 1; s.jrtgt = 32'h1000_0004;
    drive(s);
    drive(idle());
    s = idle(); s.j = 1; s.jidx = 26'h000005;
    drive(s);
    drive(idle());

    // j and jr together: jump wins.
    s = idle(); s.j = 1; s.jidx = 26'h40; s.jr = 1; s.jrtgt = 32'h300;
    drive(s);

    // Wrap of PC+4 at the top of the address space (jr low bits masked).
    s = idle(); s.jr = 1; s.jrtgt = 32'hFFFF_FFFF;
    drive(s);
    repeat (2) drive(idle());

    // Jump-to-self at 0x1D4: halts with the feature, loops without it.
    rom[53] = 32'h0800_0075;
    s = idle(); s.jr = 1; s.jrtgt = 32'h1D4;
    drive(s);
    repeat (3) begin
      drive(idle());
      s = idle(); s.j = 1; s.jidx = 26'h75;
      drive(s);
    end
    s = idle(); s.bt = 1; s.btgt = 32'h400; s.stall = 1;
    drive(s);
    drive(idle());
    s = idle(); s.rst_n = 0;
    drive(s);
    drive(idle());

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      s.rst_n = ($urandom_range(0, 39) != 0);
      s.stall = ($urandom_range(0, 3) == 0);
      s.bt    = ($urandom_range(0, 9) == 0);
      s.btgt  = (($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 255));
      s.j     = ($urandom_range(0, 9) == 0);
      s.jidx  = 26'($urandom);
      s.jr    = ($urandom_range(0, 9) == 0);
      s.jrtgt = (($urandom_range(0, 1) == 0) ? $urandom : 32'hFFFF_FFF0 + $urandom_range(0, 15));
      drive(s);
    end

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
